// File: rtl/input_memory_node_if.sv
// OBI request/response types and the bus interface between the input node
// (master) and the memory fabric (slave).
package input_memory_node_pkg;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

interface input_memory_node_if;
    import input_memory_node_pkg::*;

    obi_req_t  obi_req;
    obi_resp_t obi_resp;

    modport master (output obi_req, input obi_resp);
    modport slave  (input obi_req, output obi_resp);
endinterface

// File: rtl/input_memory_node.sv
// CGRA input node: fetches a strided run of 32-bit words over OBI and streams
// them to the fabric through a small credit-limited FIFO.
module input_memory_node
    import input_memory_node_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                clr_i,
    input  logic [31:0]         addr_i,
    input  logic [15:0]         size_i,
    input  logic [15:0]         stride_i,
    input_memory_node_if.master obi,
    output logic [31:0]         data_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                busy_o,
    output logic                done_o
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e             state_q, state_d;
    logic [31:0]        cur_addr_q, cur_addr_d;
    logic [15:0]        stride_q, stride_d;
    logic [15:0]        req_left_q, req_left_d;
    logic [15:0]        resp_left_q, resp_left_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [CNT_W-1:0]   fifo_count_q, fifo_count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               flushing_q, flushing_d;
    logic               done_q, done_d;
    logic [31:0]        fifo_mem [FIFO_DEPTH];

    logic               req;
    logic               gnt_acc;
    logic               rvalid;
    logic               push;
    logic               pop;
    logic [CNT_W:0]     credit_used;

    // Buffered plus in-flight words may never exceed the FIFO depth, so a
    // request that has been raised can only be retired by its grant.
    always_comb begin
        credit_used = {1'b0, fifo_count_q} + {1'b0, outstanding_q};
        req         = (state_q == RUN) && (req_left_q != 16'd0) &&
                      (credit_used < DEPTH_C) && !flushing_q && !clr_i;
        gnt_acc     = req && obi.obi_resp.gnt;
        rvalid      = obi.obi_resp.rvalid;
        push        = rvalid && !flushing_q && !clr_i;
        valid_o     = (fifo_count_q != '0);
        pop         = valid_o && ready_i && !clr_i;
        data_o      = valid_o ? fifo_mem[rd_ptr_q] : 32'h0;
        busy_o      = (state_q != IDLE);
        done_o      = done_q;
    end

    always_comb begin
        obi.obi_req.req   = req;
        obi.obi_req.addr  = cur_addr_q;
        obi.obi_req.we    = 1'b0;
        obi.obi_req.be    = 4'hF;
        obi.obi_req.wdata = 32'h0;
    end

    always_comb begin
        state_d       = state_q;
        cur_addr_d    = cur_addr_q;
        stride_d      = stride_q;
        req_left_d    = req_left_q;
        resp_left_d   = resp_left_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        done_d        = 1'b0;
        outstanding_d = outstanding_q + CNT_W'(gnt_acc) - CNT_W'(rvalid);
        fifo_count_d  = fifo_count_q + CNT_W'(push) - CNT_W'(pop);

        if (gnt_acc) begin
            cur_addr_d = cur_addr_q + {16'h0, stride_q};
            req_left_d = req_left_q - 16'd1;
        end
        if (push) begin
            wr_ptr_d    = wr_ptr_q + 1'b1;
            resp_left_d = resp_left_q - 16'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    cur_addr_d  = addr_i;
                    stride_d    = stride_i;
                    req_left_d  = size_i;
                    resp_left_d = size_i;
                    state_d     = (size_i == 16'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (req_left_d == 16'd0) state_d = DRAIN;
            end
            DRAIN: begin
                if ((resp_left_q == 16'd0) && (fifo_count_q == '0)) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (clr_i) begin
            state_d      = IDLE;
            fifo_count_d = '0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            done_d       = 1'b0;
        end

        // Responses still in flight after an abort belong to the old transfer.
        flushing_d = (flushing_q || clr_i) && (outstanding_d != '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            cur_addr_q    <= 32'h0;
            stride_q      <= 16'h0;
            req_left_q    <= 16'h0;
            resp_left_q   <= 16'h0;
            outstanding_q <= '0;
            fifo_count_q  <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            flushing_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_addr_q    <= cur_addr_d;
            stride_q      <= stride_d;
            req_left_q    <= req_left_d;
            resp_left_q   <= resp_left_d;
            outstanding_q <= outstanding_d;
            fifo_count_q  <= fifo_count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            flushing_q    <= flushing_d;
            done_q        <= done_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_q] <= obi.obi_resp.rdata;
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && (fifo_count_q == FULL_C)));
    a_no_stray_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(rvalid && (outstanding_q == '0)));

endmodule

// File: tb/tb_input_memory_node.sv
// Directed bench for input_memory_node: OBI memory responder with adjustable
// grant stall and response latency, plus a linear sequence of checked steps.
module tb_input_memory_node;
    import input_memory_node_pkg::*;

    logic        clk_i    = 1'b0;
    logic        rst_ni   = 1'b1;
    logic        start_i  = 1'b0;
    logic        clr_i    = 1'b0;
    logic        ready_i  = 1'b0;
    logic [31:0] addr_i   = 32'h0;
    logic [15:0] size_i   = 16'h0;
    logic [15:0] stride_i = 16'h0;
    logic [31:0] data_o;
    logic        valid_o;
    logic        busy_o;
    logic        done_o;

    input_memory_node_if bus();

    input_memory_node #(.FIFO_DEPTH(4)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (start_i),
        .clr_i   (clr_i),
        .addr_i  (addr_i),
        .size_i  (size_i),
        .stride_i(stride_i),
        .obi     (bus),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    always #5 clk_i = ~clk_i;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [31:0] addr_log [$];
    int          resp_lat      = 1;
    int          gnt_delay_idx = -1;
    int          gnt_delay_cyc = 0;
    int          gnt_waited    = 0;
    int          gnt_num       = 0;
    int          stall_cnt     = 0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Memory side: grants (optionally stalling one request) and returns
    // mem_fn(addr) resp_lat cycles after each grant.
    initial begin : responder
        logic        pipe_v [4];
        logic [31:0] pipe_d [4];
        logic        hs;
        logic        stall_prev;
        logic [31:0] stall_addr;
        stall_prev = 1'b0;
        stall_addr = 32'h0;
        bus.obi_resp = '0;
        for (int i = 0; i < 4; i++) begin
            pipe_v[i] = 1'b0;
            pipe_d[i] = 32'h0;
        end
        forever begin
            @(posedge clk_i);
            if (rst_ni) begin
                if (stall_prev && !clr_i) begin
                    check1("req_hold", bus.obi_req.req, 1'b1);
                    check("addr_hold", bus.obi_req.addr, stall_addr);
                end
                hs         = bus.obi_req.req && bus.obi_resp.gnt;
                stall_prev = bus.obi_req.req && !bus.obi_resp.gnt;
                stall_addr = bus.obi_req.addr;
                if (stall_prev) stall_cnt++;
                for (int i = 3; i > 0; i--) begin
                    pipe_v[i] = pipe_v[i-1];
                    pipe_d[i] = pipe_d[i-1];
                end
                pipe_v[0] = hs;
                pipe_d[0] = mem_fn(bus.obi_req.addr);
                if (hs) begin
                    addr_log.push_back(bus.obi_req.addr);
                    gnt_num++;
                end
            end else begin
                stall_prev = 1'b0;
                for (int i = 0; i < 4; i++) pipe_v[i] = 1'b0;
            end
            #1;
            bus.obi_resp.rvalid = rst_ni && pipe_v[resp_lat-1];
            bus.obi_resp.rdata  = pipe_v[resp_lat-1] ? pipe_d[resp_lat-1] : 32'h0;
            if (rst_ni && bus.obi_req.req && (gnt_num == gnt_delay_idx) &&
                (gnt_waited < gnt_delay_cyc)) begin
                bus.obi_resp.gnt = 1'b0;
                gnt_waited++;
            end else begin
                bus.obi_resp.gnt = rst_ni;
            end
        end
    end

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic do_start(input logic [31:0] a, input logic [15:0] s, input logic [15:0] st);
        addr_i   = a;
        size_i   = s;
        stride_i = st;
        start_i  = 1'b1;
        step();
        start_i  = 1'b0;
    endtask

    // Consumes the stream from the current cycle (cycle 1 after start),
    // checking every popped word and a single done pulse after the last pop.
    task automatic stream_check(input string tag, input logic [31:0] base, input logic [15:0] stride,
                                input int n, input int bound, output int first_valid);
        int          idx;
        int          dones;
        int          cyc;
        logic [31:0] a;
        idx = 0; dones = 0; cyc = 1; a = base; first_valid = -1;
        while (((idx < n) || (dones == 0)) && (cyc < bound)) begin
            if (valid_o && (first_valid < 0)) first_valid = cyc;
            if (valid_o && ready_i) begin
                check($sformatf("%s_data%0d", tag, idx), data_o, mem_fn(a));
                a = a + {16'h0, stride};
                idx++;
            end
            if (done_o) begin
                dones++;
                check($sformatf("%s_done_after_last", tag), idx, n);
            end
            step();
            cyc++;
        end
        check($sformatf("%s_words", tag), idx, n);
        repeat (3) begin
            if (done_o) dones++;
            step();
        end
        check($sformatf("%s_done_pulses", tag), dones, 32'd1);
        check1($sformatf("%s_busy_after", tag), busy_o, 1'b0);
    endtask

    task automatic check_addrs(input string tag, input logic [31:0] base, input logic [31:0] stride, input int n);
        check($sformatf("%s_grants", tag), addr_log.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < addr_log.size())
                check($sformatf("%s_addr%0d", tag, i), addr_log[i], base + i * stride);
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int first_v;

        // Reset values
        #2 rst_ni = 1'b0;
        step(); step();
        check1("rst_req", bus.obi_req.req, 1'b0);
        check1("rst_valid", valid_o, 1'b0);
        check1("rst_busy", busy_o, 1'b0);
        check1("rst_done", done_o, 1'b0);
        check("rst_data", data_o, 32'h0);
        rst_ni = 1'b1;
        step();

        // 1: basic 4-word stride-4 fetch, first-word latency of 3 cycles
        ready_i = 1'b1;
        addr_log.delete();
        do_start(32'h0000_1000, 16'd4, 16'd4);
        check1("t1_req_c1", bus.obi_req.req, 1'b1);
        check("t1_addr_c1", bus.obi_req.addr, 32'h0000_1000);
        check("t1_be", {28'h0, bus.obi_req.be}, 32'hF);
        check1("t1_we", bus.obi_req.we, 1'b0);
        stream_check("t1", 32'h0000_1000, 16'd4, 4, 60, first_v);
        check("t1_first_valid_cycle", first_v, 32'd3);
        check_addrs("t1", 32'h0000_1000, 32'd4, 4);
        if (addr_log.size() == 4) check("t1_last_addr", addr_log[3], 32'h0000_100C);

        // 2: zero size, done two cycles after start, no bus traffic
        addr_log.delete();
        do_start(32'h0000_3000, 16'd0, 16'd4);
        check1("t2_req_c1", bus.obi_req.req, 1'b0);
        check1("t2_done_c1", done_o, 1'b0);
        check1("t2_busy_c1", busy_o, 1'b1);
        step();
        check1("t2_done_c2", done_o, 1'b1);
        check1("t2_valid_c2", valid_o, 1'b0);
        check1("t2_busy_c2", busy_o, 1'b0);
        step();
        check1("t2_done_c3", done_o, 1'b0);
        check("t2_grants", addr_log.size(), 32'd0);

        // 3: backpressure caps grants at FIFO depth; start while busy ignored
        ready_i = 1'b0;
        addr_log.delete();
        do_start(32'h0000_4000, 16'd8, 16'd4);
        repeat (20) step();
        check("t3_grants_stalled", addr_log.size(), 32'd4);
        check1("t3_req_low", bus.obi_req.req, 1'b0);
        check1("t3_valid", valid_o, 1'b1);
        check("t3_head", data_o, mem_fn(32'h0000_4000));
        do_start(32'h0000_9000, 16'd2, 16'd4);
        repeat (3) step();
        check("t3_grants_after_restart_attempt", addr_log.size(), 32'd4);
        ready_i = 1'b1;
        stream_check("t3", 32'h0000_4000, 16'd4, 8, 100, first_v);
        check_addrs("t3", 32'h0000_4000, 32'd4, 8);

        // 4: second request stalled 3 cycles, stride 0x10
        addr_log.delete();
        stall_cnt     = 0;
        gnt_num       = 0;
        gnt_waited    = 0;
        gnt_delay_idx = 1;
        gnt_delay_cyc = 3;
        do_start(32'h0000_1000, 16'd3, 16'h0010);
        stream_check("t4", 32'h0000_1000, 16'h0010, 3, 60, first_v);
        check("t4_stall_cycles", stall_cnt, 32'd3);
        check_addrs("t4", 32'h0000_1000, 32'h10, 3);
        gnt_delay_idx = -1;

        // 5: address wrap at 2^32
        addr_log.delete();
        do_start(32'hFFFF_FFF8, 16'd3, 16'd8);
        stream_check("t5", 32'hFFFF_FFF8, 16'd8, 3, 60, first_v);
        check("t5_grants", addr_log.size(), 32'd3);
        if (addr_log.size() == 3) begin
            check("t5_addr0", addr_log[0], 32'hFFFF_FFF8);
            check("t5_addr1", addr_log[1], 32'h0000_0000);
            check("t5_addr2", addr_log[2], 32'h0000_0008);
        end

        // 6: abort with one word buffered and one response in flight
        ready_i       = 1'b0;
        resp_lat      = 2;
        addr_log.delete();
        gnt_num       = 0;
        gnt_waited    = 0;
        gnt_delay_idx = 1;
        gnt_delay_cyc = 2;
        do_start(32'h0000_5000, 16'd6, 16'd4);
        repeat (4) step();
        check("t6_grants_before_clr", addr_log.size(), 32'd2);
        check1("t6_valid_before_clr", valid_o, 1'b1);
        check("t6_head_before_clr", data_o, mem_fn(32'h0000_5000));
        check1("t6_req_before_clr", bus.obi_req.req, 1'b1);
        check("t6_addr_before_clr", bus.obi_req.addr, 32'h0000_5008);
        clr_i = 1'b1;
        #1;
        check1("t6_req_drop", bus.obi_req.req, 1'b0);
        step();
        clr_i = 1'b0;
        check1("t6_valid_flushed", valid_o, 1'b0);
        check1("t6_busy_idle", busy_o, 1'b0);
        check1("t6_no_done_a", done_o, 1'b0);
        step();
        check1("t6_late_discarded", valid_o, 1'b0);
        check1("t6_no_done_b", done_o, 1'b0);
        check("t6_grants_after_clr", addr_log.size(), 32'd2);
        gnt_delay_idx = -1;
        ready_i       = 1'b1;
        addr_log.delete();
        do_start(32'h0000_6000, 16'd3, 16'd4);
        stream_check("t6r", 32'h0000_6000, 16'd4, 3, 60, first_v);
        check_addrs("t6r", 32'h0000_6000, 32'd4, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
